// File: rtl/stop_it_controller.sv
// Stop-It game sequencer: target preview, timed LED shifting,
// stop judgement and win/lose display for the LED shifter.
module stop_it_controller #(
  parameter int SHIFT_DIV   = 4_000_000,
  parameter int BLINK_DIV   = 6_000_000,
  parameter int BLINK_COUNT = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        go_i,
  input  logic        stop_i,
  input  logic [4:0]  target_i,
  output logic        shift_o,
  output logic        load_o,
  output logic [15:0] pattern_o,
  output logic        off_o,
  output logic        win_o,
  output logic        lose_o
);

  localparam int PW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = $clog2(BLINK_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WIN,
    LOSE
  } state_t;

  state_t          state;
  logic [PW-1:0]   pre;
  logic [4:0]      step;
  logic [4:0]      tgt;
  logic [BW-1:0]   blk;
  logic [TW-1:0]   tog;
  logic            off_q;
  logic            go_q;
  logic            stop_q;

  logic            go_ev;
  logic            stop_ev;
  logic [4:0]      tgt_clamp;
  logic [16:0]     therm;
  logic            pre_wrap;
  logic            blk_wrap;
  logic            last_tog;
  logic            full;

  assign go_ev     = go_i & ~go_q;
  assign stop_ev   = stop_i & ~stop_q;
  assign tgt_clamp = (target_i > 5'd16) ? 5'd16 : target_i;
  assign therm     = (17'd1 << tgt_clamp) - 17'd1;
  assign pre_wrap  = (pre == PW'(SHIFT_DIV - 1));
  assign blk_wrap  = (blk == BW'(BLINK_DIV - 1));
  assign last_tog  = (tog == TW'(BLINK_COUNT - 1));
  assign full      = (step == 5'd16);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      pre    <= '0;
      step   <= '0;
      tgt    <= '0;
      blk    <= '0;
      tog    <= '0;
      off_q  <= 1'b0;
      go_q   <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      go_q   <= go_i;
      stop_q <= stop_i;
      unique case (state)
        IDLE: begin
          if (go_ev) begin
            tgt   <= tgt_clamp;
            state <= LOAD;
          end
        end
        LOAD: begin
          pre   <= '0;
          step  <= '0;
          state <= RUN;
        end
        RUN: begin
          if (stop_ev) begin
            state <= (step == tgt) ? WIN : LOSE;
            blk   <= '0;
            tog   <= '0;
            off_q <= 1'b0;
          end else if (go_ev) begin
            state <= LOAD;
          end else if (pre_wrap) begin
            pre <= '0;
            if (!full) begin
              step <= step + 5'd1;
            end else begin
              state <= LOSE;
              blk   <= '0;
              tog   <= '0;
              off_q <= 1'b0;
            end
          end else begin
            pre <= pre + PW'(1);
          end
        end
        WIN, LOSE: begin
          // off_q toggles in LOSE too but is masked on the output
          if (blk_wrap) begin
            blk <= '0;
            if (last_tog) begin
              state <= IDLE;
              off_q <= 1'b0;
            end else begin
              tog   <= tog + TW'(1);
              off_q <= ~off_q;
            end
          end else begin
            blk <= blk + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign shift_o   = (state == RUN) & pre_wrap & ~stop_ev & ~full;
  assign load_o    = (state == IDLE) | (state == LOAD);
  assign pattern_o = (state == IDLE) ? therm[15:0] : 16'h0000;
  assign off_o     = (state == WIN) & off_q;
  assign win_o     = (state == WIN);
  assign lose_o    = (state == LOSE);

endmodule

// File: tb/tb_stop_it_controller.sv
// Bench for stop_it_controller: directed scenarios plus random
// stimulus, all checked against a phase/time reference model.
module tb_stop_it_controller;

  localparam int SD = 4;
  localparam int BD = 3;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        stop;
  logic [4:0]  target;
  logic        shift_o;
  logic        load_o;
  logic [15:0] pattern_o;
  logic        off_o;
  logic        win_o;
  logic        lose_o;

  int npass = 0;
  int ntot  = 0;

  stop_it_controller #(
    .SHIFT_DIV  (SD),
    .BLINK_DIV  (BD),
    .BLINK_COUNT(BC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .go_i     (go),
    .stop_i   (stop),
    .target_i (target),
    .shift_o  (shift_o),
    .load_o   (load_o),
    .pattern_o(pattern_o),
    .off_o    (off_o),
    .win_o    (win_o),
    .lose_o   (lose_o)
  );

  always #5 clk = ~clk;

  // Reference model: game phase plus elapsed time within it
  typedef enum {P_IDLE, P_LOAD, P_RUN, P_WIN, P_LOSE} phase_t;
  phase_t ph;
  int     run_t;
  int     end_t;
  int     tgt;
  logic   pg;
  logic   ps;
  logic   m_go;
  logic   m_stop;
  logic        e_shift, e_load, e_off, e_win, e_lose;
  logic [15:0] e_pat;
  logic [20:0] obs;
  logic [20:0] expv;

  function automatic int clampv(input logic [4:0] t);
    return (int'(t) > 16) ? 16 : int'(t);
  endfunction

  function automatic logic [15:0] leds(input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  assign m_go   = go & ~pg;
  assign m_stop = stop & ~ps;
  assign obs  = {shift_o, load_o, pattern_o, off_o, win_o, lose_o};
  assign expv = {e_shift, e_load, e_pat, e_off, e_win, e_lose};

  always_comb begin
    e_shift = 1'b0;
    e_load  = 1'b0;
    e_pat   = 16'h0000;
    e_off   = 1'b0;
    e_win   = 1'b0;
    e_lose  = 1'b0;
    case (ph)
      P_IDLE: begin
        e_load = 1'b1;
        e_pat  = leds(clampv(target));
      end
      P_LOAD: e_load = 1'b1;
      P_RUN: e_shift = (run_t % SD == SD - 1) && !m_stop
                       && (run_t / SD < 16);
      P_WIN: begin
        e_win = 1'b1;
        e_off = ((end_t / BD) % 2) == 1;
      end
      default: e_lose = 1'b1;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph    <= P_IDLE;
      pg    <= 1'b0;
      ps    <= 1'b0;
      run_t <= 0;
      end_t <= 0;
      tgt   <= 0;
    end else begin
      pg <= go;
      ps <= stop;
      case (ph)
        P_IDLE: if (m_go) begin
          tgt <= clampv(target);
          ph  <= P_LOAD;
        end
        P_LOAD: begin
          run_t <= 0;
          ph    <= P_RUN;
        end
        P_RUN: begin
          if (m_stop) begin
            ph    <= (run_t / SD == tgt) ? P_WIN : P_LOSE;
            end_t <= 0;
          end else if (m_go) begin
            ph <= P_LOAD;
          end else if (run_t % SD == SD - 1 && run_t / SD == 16) begin
            ph    <= P_LOSE;
            end_t <= 0;
          end else begin
            run_t <= run_t + 1;
          end
        end
        default: begin
          if (end_t == BD * BC - 1) ph <= P_IDLE;
          else end_t <= end_t + 1;
        end
      endcase
    end
  end

  task automatic tick(input logic g, input logic s);
    @(posedge clk);
    #1;
    go   = g;
    stop = s;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    go = 1'b0;
    stop = 1'b0;
    target = 5'd5;
    #12;
    ntot++;
    if (obs !== 21'({1'b0, 1'b1, 16'h001F, 3'b000}))
      $display("FAIL reset_outputs obs=%h want=%h",
               obs, 21'({1'b0, 1'b1, 16'h001F, 3'b000}));
    else npass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    ntot++;
    if (obs !== expv) $display("FAIL reset_model obs=%h exp=%h", obs, expv);
    else npass++;
  endtask

  task automatic test_win;
    int n;
    int k;
    target = 5'd5;
    tick(0, 0);
    tick(1, 0);
    n = 0;
    k = 0;
    while (n < 5 && k < 100) begin
      tick(1, 0);
      if (shift_o) n++;
      k++;
      ntot++;
      if (obs !== expv) $display("FAIL win_run obs=%h exp=%h", obs, expv);
      else npass++;
    end
    ntot++;
    if (n != 5) $display("FAIL win_shifts got=%0d want=5", n);
    else npass++;
    tick(1, 1);
    for (int i = 0; i < BD * BC; i++) begin
      tick(0, 0);
      ntot++;
      if (win_o !== 1'b1 || lose_o !== 1'b0 || off_o !== 1'(((i / 3) % 2)))
        $display("FAIL win_blink i=%0d win=%b off=%b want off=%0d",
                 i, win_o, off_o, (i / 3) % 2);
      else npass++;
    end
    tick(0, 0);
    ntot++;
    if (win_o !== 1'b0 || load_o !== 1'b1 || obs !== expv)
      $display("FAIL win_to_idle obs=%h exp=%h", obs, expv);
    else npass++;
  endtask

  task automatic test_lose;
    int n;
    int k;
    target = 5'd5;
    tick(0, 0);
    tick(1, 0);
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      tick(1, 0);
      if (shift_o) n++;
      k++;
    end
    tick(0, 1);
    for (int i = 0; i < BD * BC; i++) begin
      tick(0, 0);
      ntot++;
      if (lose_o !== 1'b1 || off_o !== 1'b0 || obs !== expv)
        $display("FAIL lose_hold i=%0d obs=%h exp=%h", i, obs, expv);
      else npass++;
    end
    tick(0, 0);
    ntot++;
    if (lose_o !== 1'b0 || load_o !== 1'b1)
      $display("FAIL lose_to_idle lose=%b load=%b want 0 1", lose_o, load_o);
    else npass++;
  endtask

  task automatic test_timeout;
    int n;
    int k;
    target = 5'd20;
    tick(0, 0);
    ntot++;
    if (pattern_o !== 16'hFFFF)
      $display("FAIL clamp_pattern got=%h want=ffff", pattern_o);
    else npass++;
    tick(1, 0);
    n = 0;
    k = 0;
    while (!lose_o && k < 200) begin
      tick(0, 0);
      if (shift_o) n++;
      k++;
      ntot++;
      if (obs !== expv) $display("FAIL timeout_run obs=%h exp=%h", obs, expv);
      else npass++;
    end
    ntot++;
    if (n != 16 || lose_o !== 1'b1)
      $display("FAIL timeout_shifts got=%0d lose=%b want 16 1", n, lose_o);
    else npass++;
    repeat (BD * BC) tick(0, 0);
  endtask

  task automatic test_stop_on_wrap;
    int n;
    int k;
    target = 5'd5;
    tick(0, 0);
    tick(1, 0);
    n = 0;
    k = 0;
    while (n < 4 && k < 100) begin
      tick(1, 0);
      if (shift_o) n++;
      k++;
    end
    repeat (SD - 1) tick(1, 0);
    tick(1, 1);
    ntot++;
    if (shift_o !== 1'b0 || obs !== expv)
      $display("FAIL wrap_stop_shift got=%b want=0", shift_o);
    else npass++;
    tick(0, 0);
    ntot++;
    if (lose_o !== 1'b1 || win_o !== 1'b0)
      $display("FAIL wrap_stop_lose lose=%b win=%b want 1 0", lose_o, win_o);
    else npass++;
    repeat (BD * BC) tick(0, 0);
  endtask

  task automatic test_restart;
    int loads;
    int k;
    target = 5'd5;
    @(posedge clk);
    #1;
    rst = 1'b1;
    go  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    loads = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0);
      if (load_o && pattern_o == 16'h0000) loads++;
      ntot++;
      if (obs !== expv) $display("FAIL held_go obs=%h exp=%h", obs, expv);
      else npass++;
    end
    ntot++;
    if (loads != 1) $display("FAIL held_go_loads got=%0d want=1", loads);
    else npass++;
    tick(0, 0);
    tick(1, 0);
    tick(1, 0);
    ntot++;
    if (load_o !== 1'b1 || pattern_o !== 16'h0000)
      $display("FAIL restart_load load=%b pat=%h want 1 0000", load_o, pattern_o);
    else npass++;
    k = 0;
    do begin
      tick(1, 0);
      k++;
    end while (!shift_o && k < 10);
    ntot++;
    if (k != SD) $display("FAIL restart_first_shift got=%0d want=%0d", k, SD);
    else npass++;
    repeat (SD - 1) tick(1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    ntot++;
    if (obs !== 21'({1'b0, 1'b1, 16'h001F, 3'b000}))
      $display("FAIL mid_reset obs=%h want=%h",
               obs, 21'({1'b0, 1'b1, 16'h001F, 3'b000}));
    else npass++;
    go = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      rst  = ($urandom_range(0, 299) == 0);
      go   = ($urandom_range(0, 39) == 0);
      stop = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) target = 5'($urandom_range(0, 31));
      @(negedge clk);
      ntot++;
      if (obs !== expv)
        $display("FAIL random i=%0d obs=%h exp=%h", i, obs, expv);
      else npass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_timeout();
    test_stop_on_wrap();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
